// File: rtl/morse_char_buffer.sv
// Decodes completed Morse symbol groups to ASCII and queues them in a first-word-fall-through FIFO.
// Optional macro MORSE_PUNCT_EN adds the five-symbol punctuation marks / = + (.
module morse_char_buffer #(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  ERR_CHAR = 8'h3F,
    localparam int         ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [9:0]        inbits,
    input  logic              spa_end,
    input  logic              sent,
    input  logic              Clear,
    input  logic              rd_en,
    output logic [7:0]        char_out,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              bad_code,
    output logic              overflow
);

    typedef enum logic [1:0] {S_START, S_CHAR, S_SPACE} space_state_t;

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    // Handshake: a rising edge on sent is one producer event (no back-pressure; a write that
    // finds the FIFO full is dropped and flagged); rd_en pops the head only while !empty.
    logic                 flush;
    logic                 sent_q;
    logic                 evt;
    logic                 s1_valid;
    logic                 s1_gap;
    logic                 s1_bad;
    logic [7:0]           s1_byte;
    space_state_t         state, state_n;
    logic                 wr_req;
    logic [7:0]           wr_byte;
    logic                 do_wr;
    logic                 do_rd;
    logic                 drop;
    logic [7:0]           mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;

    // Walks the symbols into a binary-tree index (dot = 0, dash = 1) rooted at 1,
    // so every symbol count and pattern lands on a unique index.
    function automatic logic [8:0] decode(input logic [9:0] bits);
        logic [5:0] idx;
        logic       seen_gap;
        logic       bad;
        logic       found;
        logic [7:0] ch;
        idx      = 6'd1;
        seen_gap = 1'b0;
        bad      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            case (bits[2*k +: 2])
                2'b00:   seen_gap = 1'b1;
                2'b11:   bad = 1'b1;
                default: begin
                    if (seen_gap) bad = 1'b1;
                    idx = {idx[4:0], bits[2*k+1]};
                end
            endcase
        end
        found = 1'b1;
        ch    = ERR_CHAR;
        case (idx)
            6'd5:  ch = 8'h41; 6'd24: ch = 8'h42; 6'd26: ch = 8'h43; 6'd12: ch = 8'h44;
            6'd2:  ch = 8'h45; 6'd18: ch = 8'h46; 6'd14: ch = 8'h47; 6'd16: ch = 8'h48;
            6'd4:  ch = 8'h49; 6'd23: ch = 8'h4A; 6'd13: ch = 8'h4B; 6'd20: ch = 8'h4C;
            6'd7:  ch = 8'h4D; 6'd6:  ch = 8'h4E; 6'd15: ch = 8'h4F; 6'd22: ch = 8'h50;
            6'd29: ch = 8'h51; 6'd10: ch = 8'h52; 6'd8:  ch = 8'h53; 6'd3:  ch = 8'h54;
            6'd9:  ch = 8'h55; 6'd17: ch = 8'h56; 6'd11: ch = 8'h57; 6'd25: ch = 8'h58;
            6'd27: ch = 8'h59; 6'd28: ch = 8'h5A;
            6'd63: ch = 8'h30; 6'd47: ch = 8'h31; 6'd39: ch = 8'h32; 6'd35: ch = 8'h33;
            6'd33: ch = 8'h34; 6'd32: ch = 8'h35; 6'd48: ch = 8'h36; 6'd56: ch = 8'h37;
            6'd60: ch = 8'h38; 6'd62: ch = 8'h39;
`ifdef MORSE_PUNCT_EN
            6'd50: ch = 8'h2F; 6'd49: ch = 8'h3D; 6'd42: ch = 8'h2B; 6'd54: ch = 8'h28;
`endif
            default: found = 1'b0;
        endcase
        if (bad || !found) return {1'b1, ERR_CHAR};
        return {1'b0, ch};
    endfunction

    assign flush = Reset | Clear;
    assign evt   = sent & ~sent_q;

    // sent_q follows sent even through a flush so a held level is never re-counted.
    always_ff @(posedge clk) begin
        sent_q <= sent;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid <= 1'b0;
            s1_gap   <= 1'b0;
            s1_bad   <= 1'b0;
            s1_byte  <= 8'h00;
        end else begin
            s1_valid <= evt;
            s1_gap   <= spa_end;
            {s1_bad, s1_byte} <= decode(inbits);
        end
    end

    always_ff @(posedge clk) begin
        if (flush) state <= S_START;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        wr_req  = 1'b0;
        wr_byte = s1_byte;
        if (s1_valid) begin
            if (s1_gap) begin
                if (state == S_CHAR) begin
                    wr_req  = 1'b1;
                    wr_byte = 8'h20;
                    state_n = S_SPACE;
                end
            end else begin
                wr_req  = 1'b1;
                state_n = S_CHAR;
            end
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_rd    = rd_en & ~empty;
    assign do_wr    = wr_req & (~full | do_rd);
    assign drop     = wr_req & full & ~do_rd;
    assign bad_code = s1_valid & ~s1_gap & s1_bad;
    assign char_out = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!flush && do_wr) mem[wr_ptr] <= wr_byte;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

endmodule
